// File: rtl/approx_arith_pkg.sv
// Shared types and helpers for the approximate arithmetic blocks.
package approx_arith_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StDiv,
        StOut
    } div_state_e;

    localparam int unsigned DefW   = 16;
    localparam int unsigned DefNum = 6;

    // Width of a counter that must reach 2*num-1.
    function automatic int unsigned iter_cnt_width(input int unsigned num);
        return $clog2(2 * num);
    endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Combinational priority encoder: position of the most significant set bit.
// pos_o is 0 when the input is zero; zero_o distinguishes that case from bit 0.
module leading_one_detect
    import approx_arith_pkg::*;
#(
    parameter int unsigned W    = DefW,
    parameter int unsigned PosW = $clog2(W)
) (
    input  logic [W-1:0]    data_i,
    output logic [PosW-1:0] pos_o,
    output logic            zero_o
);

    // Scan upwards so the highest set bit is the last one written.
    always_comb begin
        pos_o = '0;
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                pos_o = PosW'(i);
            end
        end
        zero_o = ~|data_i;
    end

endmodule

// File: rtl/approx_divider_1.sv
// Sequential approximate unsigned divider. Each operand is cut down to its top
// NUM bits at the leading one, a 2*NUM-step restoring division runs on the short
// operands, and the quotient is rescaled by the difference of the truncation shifts.
// Legal parameters: NUM >= 2 and 2*NUM <= W < 32.
module approx_divider_1
    import approx_arith_pkg::*;
#(
    parameter int unsigned W   = DefW,
    parameter int unsigned NUM = DefNum
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic         div_by_zero
);

    localparam int unsigned PosW = $clog2(W);
    localparam int unsigned QW   = 2 * NUM;
    localparam int unsigned RW   = NUM + 1;
    localparam int unsigned CntW = iter_cnt_width(NUM);

    localparam logic [PosW-1:0] KeepTop  = PosW'(NUM - 1);
    localparam logic [CntW-1:0] LastIter = CntW'(QW - 1);

    div_state_e state_q, state_d;

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [PosW-1:0] sa_q, sa_d;
    logic [PosW-1:0] sb_q, sb_d;
    logic [NUM-1:0]  n_q, n_d;
    logic [QW-1:0]   dvd_q, dvd_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    q_q, q_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;

    logic [PosW-1:0] k, l;
    logic            a_zero, b_zero;
    logic [PosW-1:0] sa, sb;
    logic [NUM-1:0]  m, n;

    logic [RW-1:0]   rem_shift;
    logic [RW:0]     trial;

    int              d;
    logic [31:0]     scaled;
    logic [W-1:0]    q_res;

    leading_one_detect #(
        .W    (W),
        .PosW (PosW)
    ) u_lod_a (
        .data_i (a_q),
        .pos_o  (k),
        .zero_o (a_zero)
    );

    leading_one_detect #(
        .W    (W),
        .PosW (PosW)
    ) u_lod_b (
        .data_i (b_q),
        .pos_o  (l),
        .zero_o (b_zero)
    );

    // Truncation shifts and the kept NUM-bit operand windows.
    always_comb begin
        sa = (!a_zero && (k > KeepTop)) ? (k - KeepTop) : '0;
        sb = (!b_zero && (l > KeepTop)) ? (l - KeepTop) : '0;
        m  = NUM'(a_q >> sa);
        n  = NUM'(b_q >> sb);
    end

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem_q[NUM-1:0], dvd_q[QW-1]};
        trial     = {1'b0, rem_shift} - {2'b00, n_q};
    end

    // Rescale the raw quotient by sa - sb - NUM and saturate to W bits.
    always_comb begin
        d = int'(sa_q) - int'(sb_q) - int'(NUM);
        if (d >= 0) begin
            scaled = 32'(quo_q) << d;
        end else begin
            scaled = 32'(quo_q) >> (-d);
        end
        q_res = ((scaled >> W) != 32'd0) ? '1 : scaled[W-1:0];
    end

    // Next-state and datapath update for the four-state sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        n_d     = n_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        q_d     = q_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                sa_d    = sa;
                sb_d    = sb;
                n_d     = n;
                dz_d    = b_zero;
                dvd_d   = {m, {NUM{1'b0}}};
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = b_zero ? StOut : StDiv;
            end
            StDiv: begin
                // trial MSB set means the subtraction went negative: restore.
                rem_d = trial[RW] ? rem_shift : trial[RW-1:0];
                quo_d = {quo_q[QW-2:0], ~trial[RW]};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                q_d     = dz_q ? '1 : q_res;
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            n_q    <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            dz_q   <= 1'b0;
            q_q    <= '0;
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            n_q    <= n_d;
            dvd_q  <= dvd_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            dz_q   <= dz_d;
            q_q    <= q_d;
            dbz_q  <= dbz_d;
            done_q <= done_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign q           = q_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_approx_divider_1.sv
// Self-checking bench for approx_divider_1: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_approx_divider_1;

    localparam int W   = 16;
    localparam int NUM = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_divider_1 #(
        .W   (W),
        .NUM (NUM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .div_by_zero (div_by_zero)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: truncate each operand to NUM bits at its leading one, divide
    // exactly, rescale by 2^(sa-sb-NUM), saturate.
    function automatic void ref_div(input int unsigned av, input int unsigned bv,
                                    output int unsigned qv, output bit dz);
        int k, l, sa, sb, dd;
        int unsigned m, n, qraw;
        longint unsigned r;
        dz = (bv == 0);
        qv = (1 << W) - 1;
        if (dz) return;
        k = 0;
        l = 0;
        for (int i = 0; i < W; i++) begin
            if (((av >> i) & 1) != 0) k = i;
            if (((bv >> i) & 1) != 0) l = i;
        end
        sa   = (k - NUM + 1 > 0) ? k - NUM + 1 : 0;
        sb   = (l - NUM + 1 > 0) ? l - NUM + 1 : 0;
        m    = av >> sa;
        n    = bv >> sb;
        qraw = (m << NUM) / n;
        dd   = sa - sb - NUM;
        if (dd >= 0) r = longint'(qraw) << dd;
        else         r = longint'(qraw >> (-dd));
        qv = (r > longint'((1 << W) - 1)) ? (1 << W) - 1 : int'(r);
    endfunction

    // Issue one op; lat = edges from acceptance to the first cycle with done.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = busy;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && lat < 40);
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        int          lat;
        bit          bok;
        int unsigned eq;
        bit          edz;
        run_op(av, bv, lat, bok);
        ref_div(av, bv, eq, edz);
        check_eq({tag, "_latency"}, lat, edz ? 2 : 2 * NUM + 2);
        check_eq({tag, "_q"}, q, eq);
        check_eq({tag, "_dz"}, div_by_zero, edz);
        check_eq({tag, "_busy"}, bok, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int unsigned eq;
        bit          edz;
        logic [W-1:0] ha1, hb1, ha2, hb2;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_q", q, 0);
        check_eq("reset_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases against the hand-derived values.
        check_op("d100_7", 16'd100, 16'd7);
        check_eq("d100_7_const", q, 14);
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done, 0);
        check_eq("q_holds", q, 14);

        check_op("d1000_10", 16'd1000, 16'd10);
        check_eq("d1000_10_const", q, 99);
        check_op("d40000_300", 16'd40000, 16'd300);
        check_eq("d40000_300_const", q, 134);
        check_op("d65535_1", 16'd65535, 16'd1);
        check_eq("d65535_1_const", q, 64512);
        check_op("d5_9", 16'd5, 16'd9);
        check_eq("d5_9_const", q, 0);
        check_op("d0_5", 16'd0, 16'd5);
        check_eq("d0_5_const", q, 0);

        check_op("dz1234", 16'd1234, 16'd0);
        check_eq("dz1234_const_q", q, 16'hFFFF);
        check_eq("dz1234_const_dz", div_by_zero, 1);
        check_op("after_dz", 16'd100, 16'd7);
        check_eq("after_dz_const", q, 14);

        // start held high with operands changing while busy.
        ha1 = 16'd40000;
        hb1 = 16'd300;
        @(negedge clk);
        start = 1'b1;
        a     = ha1;
        b     = hb1;
        @(posedge clk);
        #1;
        lat = 0;
        do begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
        check_eq("held1_latency", lat, 2 * NUM + 2);
        ref_div(ha1, hb1, eq, edz);
        check_eq("held1_q", q, eq);
        ha2 = W'($urandom_range(1, 65535));
        hb2 = W'($urandom_range(1, 65535));
        @(negedge clk);
        a = ha2;
        b = hb2;
        @(posedge clk);
        #1;
        check_eq("held_reaccept_busy", busy, 1);
        lat = 0;
        do begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
        check_eq("held2_latency", lat, 2 * NUM + 2);
        ref_div(ha2, hb2, eq, edz);
        check_eq("held2_q", q, eq);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("held_release_idle", busy, 0);

        // Reset in the middle of the divide loop.
        @(negedge clk);
        start = 1'b1;
        a     = 16'd1000;
        b     = 16'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_q", q, 0);
        @(negedge clk);
        rst = 1'b0;
        check_op("post_rst", 16'd40000, 16'd300);
        check_eq("post_rst_const", q, 134);

        // Randomized operations with a bias toward small and zero divisors.
        for (int i = 0; i < 40; i++) begin
            int unsigned sel;
            logic [W-1:0] ra, rb;
            sel = $urandom_range(0, 9);
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 80)) : W'($urandom);
            if (sel == 0)      rb = '0;
            else if (sel < 4)  rb = W'($urandom_range(1, 63));
            else               rb = W'($urandom_range(1, 65535));
            check_op($sformatf("rnd%0d", i), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_divider_1.md
Name: approx_divider_1

Overview:
- Sequential approximate unsigned divider; the inverse operation of the scheme-1 approximate multiplier.
- Uses the same leading-one truncation: each operand is reduced to its top NUM bits before a short restoring division, and the result is rescaled by the truncation shifts.
- Sits beside the approximate multipliers in the low-power datapath and trades accuracy for a 2*NUM-iteration divide core.

Parameters:
- W, 16, operand and quotient width.
- NUM, 6, kept (truncated) bits per operand. Legal range: 2 <= NUM and 2*NUM <= W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only in IDLE
- a  in  W  dividend, unsigned
- b  in  W  divisor, unsigned
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; q and div_by_zero are valid from this cycle
- q  out  W  approximate quotient; holds until the next done
- div_by_zero  out  1  set with done when b was 0; holds until the next done

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, q=0, div_by_zero=0. Reset mid-operation aborts the operation immediately and does not pulse done.
- States:
  - IDLE -> NORM on start=1. a and b are captured into internal registers; start in other states is ignored.
  - NORM (1 cycle):
    - k and l = leading-one positions of a and b (0 if the operand is 0).
    - sa = max(k-NUM+1, 0) and sb = max(l-NUM+1, 0).
    - m = a>>sa and n = b>>sb, NUM bits each.
    - If b==0, go to OUT with the dz flag set; otherwise load dividend m<<NUM (2*NUM bits), clear remainder (NUM+1 bits) and quotient, and go to DIV.
  - DIV (exactly 2*NUM cycles): one restoring step per cycle. Shift the next dividend MSB into the remainder, trial-subtract n, set the quotient bit if the result is non-negative. An iteration counter counts 0..2*NUM-1 and the state goes to OUT after the last step.
  - OUT (1 cycle):
    - d = sa - sb - NUM (signed).
    - Qraw (2*NUM bits) is shifted left by d if d>=0, else shifted right by -d with truncation, in a 32-bit intermediate.
    - If the result is > 2^W-1, q = all ones. If the dz flag is set, q = all ones and div_by_zero=1; otherwise div_by_zero=0.
    - done=1 for this cycle only, busy=0 next cycle, next state IDLE.
- Latency: start sampled at edge t; done high in the cycle after edge t+2*NUM+2 (14 cycles for NUM=6). For the b==0 case, done follows edge t+2.
- Throughput: a new start is accepted in the IDLE cycle after done. There is no back-to-back acceptance in OUT.
- a==0 takes the normal path and gives q=0.
- When k<NUM or l<NUM the operand is kept whole (sa or sb = 0).

Decomposition:
- Package approx_arith_pkg:
  - state enum {IDLE, NORM, DIV, OUT};
  - default W/NUM localparams;
  - function clog2-based counter width for 2*NUM.
- One sub-module: leading_one_detect, a combinational W-bit priority encoder returning position and a zero flag. It is instantiated twice (a and b) and is reusable by the multiplier variants.

Test Plan:
- a=100, b=7, start pulse -> done exactly 14 cycles after start, q=14, div_by_zero=0; busy high throughout.
- a=1000, b=10 -> q=99 (exact value 100; checks truncation on the dividend). Then a=40000, b=300 -> q=134 (exact 133; both operands truncated, d=+1).
- a=65535, b=1 -> q=64512, no saturation. Then a=5, b=9 -> q=0 (d=-6 right shift).
- a=1234, b=0 -> done 2 cycles after start, q=16'hFFFF, div_by_zero=1. The next op a=100, b=7 clears div_by_zero with q=14.
- start held high continuously with changing a/b during DIV -> the operands latched at acceptance are used and the in-flight result is unchanged. A new op starts only from IDLE after done.
- Assert rst mid-DIV -> busy=0, done=0, q=0 on the next edge. The following start completes normally with correct q.
